// File: rtl/pipe_addsub_pkg.sv
// Shared constants and elaboration helpers for the pipelined add/subtract unit.
package pipe_addsub_pkg;

   // Encoding of the sub input.
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Segment width of one pipeline stage; 0 flags an illegal WIDTH/STAGES pairing.
   function automatic int unsigned seg_width(input int unsigned width,
                                             input int unsigned stages);
      if (stages == 0 || width < 2) begin
         return 0;
      end
      if ((width % stages) != 0) begin
         return 0;
      end
      return width / stages;
   endfunction

endpackage

// File: rtl/addsub_seg.sv
// Combinational SEG-bit slice adder: sum, carry-out and the carry into the slice MSB.
module addsub_seg #(
   parameter int unsigned SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout,
   output logic           cmsb
);

   logic [SEG:0] full;

   assign full = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
   assign sum  = full[SEG-1:0];
   assign cout = full[SEG];
   // Carry into the MSB recovered from the MSB's own sum bit.
   assign cmsb = a[SEG-1] ^ b[SEG-1] ^ sum[SEG-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES registered segments,
// with valid/ready flow control, collapsing bubbles and a pass-through tag.
module pipe_addsub
   import pipe_addsub_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4,
   parameter int unsigned TAG_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned SEG = seg_width(WIDTH, STAGES);

   if (SEG == 0 || TAG_W == 0) begin : g_bad_cfg
      $fatal(1, "pipe_addsub: illegal WIDTH/STAGES/TAG_W combination");
   end

   // Subtract is folded into the operands here, so no stage needs to carry the op.
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   assign b_eff   = (sub == OP_SUB) ? ~b : b;
   assign cin_eff = (sub == OP_ADD) ? cin : ~cin;

   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_in;
   logic [STAGES:0]   ld;

   // A stage may load when it is empty or its occupant moves on this cycle.
   always_comb begin
      ld[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         ld[k] = !v_q[k] || ld[k+1];
      end
   end

   always_comb begin
      v_in[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         v_in[k] = v_q[k-1];
      end
   end

   assign in_ready = ld[0] && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) begin
               v_q[k] <= v_in[k];
            end
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned OPW = (STAGES - k) * SEG;
      localparam int unsigned SW  = (k + 1) * SEG;

      logic [OPW-1:0]   op_a;
      logic [OPW-1:0]   op_b;
      logic             c_in;
      logic [TAG_W-1:0] t_in;
      logic [SEG-1:0]   seg_sum;
      logic             seg_cout;
      logic             seg_cmsb;
      logic [SW-1:0]    s_d;
      logic [SW-1:0]    s_q;
      logic             c_q;
      logic [TAG_W-1:0] tag_q;
      logic             en;

      if (k == 0) begin : g_entry
         assign op_a = a;
         assign op_b = b_eff;
         assign c_in = cin_eff;
         assign t_in = in_tag;
         assign s_d  = seg_sum;
      end else begin : g_chain
         assign op_a = g_stage[k-1].g_skew.a_q;
         assign op_b = g_stage[k-1].g_skew.b_q;
         assign c_in = g_stage[k-1].c_q;
         assign t_in = g_stage[k-1].tag_q;
         assign s_d  = {seg_sum, g_stage[k-1].s_q};
      end

      // Data only moves with a valid beat, so a stalled or drained output holds its value.
      assign en = ld[k] && v_in[k];

      addsub_seg #(
         .SEG (SEG)
      ) u_seg (
         .a    (op_a[SEG-1:0]),
         .b    (op_b[SEG-1:0]),
         .cin  (c_in),
         .sum  (seg_sum),
         .cout (seg_cout),
         .cmsb (seg_cmsb)
      );

      always_ff @(posedge clk) begin
         if (rst) begin
            s_q   <= '0;
            c_q   <= 1'b0;
            tag_q <= '0;
         end else if (en) begin
            s_q   <= s_d;
            c_q   <= seg_cout;
            tag_q <= t_in;
         end
      end

      if (k < STAGES - 1) begin : g_skew
         // Operand bits not yet consumed by the carry chain.
         logic [OPW-SEG-1:0] a_q;
         logic [OPW-SEG-1:0] b_q;
         logic               unused_cmsb;

         assign unused_cmsb = seg_cmsb;

         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (en) begin
               a_q <= op_a[OPW-1:SEG];
               b_q <= op_b[OPW-1:SEG];
            end
         end
      end else begin : g_last
         logic ovf_q;
         logic zero_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (en) begin
               ovf_q  <= seg_cmsb ^ seg_cout;
               zero_q <= (s_d == '0);
            end
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign s         = g_stage[STAGES-1].s_q;
   assign cout      = g_stage[STAGES-1].c_q;
   assign ovf       = g_stage[STAGES-1].g_last.ovf_q;
   assign zero      = g_stage[STAGES-1].g_last.zero_q;
   assign out_tag   = g_stage[STAGES-1].tag_q;

endmodule
